// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: bus-facing receive controller for the UART receiver datapath.
// Captures completed bytes into a receive FIFO and flags break and overrun
// conditions. It also raises a level interrupt and exposes a 4-register window
// to the 65C02 I/O decode.
//
// Register window (addr):
//   0 DATA   R: FIFO head, pops one entry (0x00 when empty). W: ignored.
//   1 STATUS R: {irq,000,break,overrun,full,not_empty}. W: 1-to-clear bits 3:2.
//   2 CTRL   R/W: bit0 rx_enable, bit1 irq_data_en, bit2 irq_err_en,
//            bit3 flush (write-only, self-clearing).
//   3 COUNT  R: FIFO occupancy, zero-extended. W: ignored.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   rx_valid/rx_break/rx_data  receiver byte-complete pulse, break, payload
//   rx_en               receiver enable (CTRL bit0)
//   cs/we/addr/wdata    register access, one per cycle while cs=1
//   rdata               registered read data, valid the cycle after the read
//   irq                 registered level interrupt
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rx_valid,
  input  logic                    rx_break,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_en,
  input  logic                    cs,
  input  logic                    we,
  input  logic [1:0]              addr,
  input  logic [7:0]              wdata,
  output logic [7:0]              rdata,
  output logic                    irq
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  // Elaboration-time parameter sanity
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_rx_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((PAYLOAD_BITS < 1) || (PAYLOAD_BITS > 8)) begin : g_bad_payload
    $error("uart_rx_ctrl: PAYLOAD_BITS must be 1..8");
  end

  // State
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [2:0]       ctrl_q;
  logic             ovr_q;
  logic             brk_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       rdata_q;
  logic             irq_q;

  // Next-state / strobes
  logic             rd_c;
  logic             wr_c;
  logic             not_empty_c;
  logic             full_c;
  logic             pop_c;
  logic             flush_c;
  logic             rx_ok_c;
  logic             push_req_c;
  logic             push_c;
  logic [7:0]       head_c;
  logic [2:0]       ctrl_n;
  logic             ovr_n;
  logic             brk_n;
  logic [PTR_W-1:0] wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] count_n;
  logic [7:0]       rdata_n;
  logic             irq_n;

  // Upper write-data bits have no function in any register
  logic unused_wdata;
  assign unused_wdata = ^wdata[7:4];

  assign rx_en = ctrl_q[0];
  assign rdata = rdata_q;
  assign irq   = irq_q;

  // Access decode, FIFO control, flag and register next-state
  always_comb begin
    rd_c        = cs & ~we;
    wr_c        = cs & we;
    not_empty_c = (count_q != '0);
    full_c      = (count_q == CNT_W'(FIFO_DEPTH));

    head_c = '0;
    head_c[PAYLOAD_BITS-1:0] = mem[rd_ptr_q];

    pop_c      = rd_c & (addr == ADDR_DATA) & not_empty_c;
    flush_c    = wr_c & (addr == ADDR_CTRL) & wdata[3];
    rx_ok_c    = rx_valid & ctrl_q[0];
    push_req_c = rx_ok_c & ~rx_break & ~flush_c;
    // A full FIFO still accepts a byte when the head leaves on the same edge
    push_c     = push_req_c & (~full_c | pop_c);

    ctrl_n   = ctrl_q;
    ovr_n    = ovr_q;
    brk_n    = brk_q;
    wr_ptr_n = wr_ptr_q;
    rd_ptr_n = rd_ptr_q;
    count_n  = count_q;
    rdata_n  = rdata_q;

    if (wr_c && (addr == ADDR_CTRL)) begin
      ctrl_n = wdata[2:0];
    end

    // W1C first so a same-cycle set wins
    if (wr_c && (addr == ADDR_STATUS)) begin
      if (wdata[2]) ovr_n = 1'b0;
      if (wdata[3]) brk_n = 1'b0;
    end
    if (push_req_c && full_c && !pop_c) ovr_n = 1'b1;
    if (rx_ok_c && rx_break)            brk_n = 1'b1;

    if (flush_c) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (push_c) wr_ptr_n = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_n = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_n = count_q + CNT_W'(1);
        2'b01:   count_n = count_q - CNT_W'(1);
        default: count_n = count_q;
      endcase
    end

    if (rd_c) begin
      case (addr)
        ADDR_DATA:   rdata_n = not_empty_c ? head_c : 8'h00;
        ADDR_STATUS: rdata_n = {irq_q, 3'b000, brk_q, ovr_q, full_c, not_empty_c};
        ADDR_CTRL:   rdata_n = {5'b00000, ctrl_q};
        default:     rdata_n = 8'(count_q);
      endcase
    end

    irq_n = (ctrl_q[1] & not_empty_c) | (ctrl_q[2] & (ovr_q | brk_q));
  end

  // Control/status registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q   <= 3'b001;
      ovr_q    <= 1'b0;
      brk_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_n;
      ovr_q    <= ovr_n;
      brk_q    <= brk_n;
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      count_q  <= count_n;
      rdata_q  <= rdata_n;
      irq_q    <= irq_n;
    end
  end

  // FIFO storage; contents are unreachable after reset so no reset needed
  always_ff @(posedge clk) begin
    if (resetn && push_c) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed, table-driven bench for uart_rx_ctrl (FIFO_DEPTH=16, PAYLOAD_BITS=8).
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_valid;
  logic       rx_break;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .PAYLOAD_BITS(8)) dut (
    .clk(clk), .resetn(resetn),
    .rx_valid(rx_valid), .rx_break(rx_break), .rx_data(rx_data),
    .rx_en(rx_en),
    .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq)
  );

  typedef struct {
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       rxv;
    logic       rxb;
    logic [7:0] rxd;
    logic [2:0] chk;      // bit0 rdata, bit1 irq, bit2 rx_en
    logic [7:0] exp_rd;
    logic       exp_irq;
    logic       exp_en;
    string      name;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic w, input logic [1:0] a, input logic [7:0] d,
                     input logic v, input logic b, input logic [7:0] rd,
                     input logic [2:0] chk, input logic [7:0] e_rd, input logic e_irq,
                     input logic e_en, input string name);
    vec_t t;
    t.cs = c; t.we = w; t.addr = a; t.wdata = d;
    t.rxv = v; t.rxb = b; t.rxd = rd;
    t.chk = chk; t.exp_rd = e_rd; t.exp_irq = e_irq; t.exp_en = e_en; t.name = name;
    tbl.push_back(t);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string name);
    add(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 8'h00, 3'b001, e, 1'b0, 1'b0, name);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    add(1'b1, 1'b1, a, d, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, "wr");
  endtask
  task automatic rx(input logic [7:0] d);
    add(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, d, 3'b000, 8'h00, 1'b0, 1'b0, "rx");
  endtask
  task automatic idle_irq(input logic e, input string name);
    add(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 3'b010, 8'h00, e, 1'b0, name);
  endtask

  // One cycle: drive on falling edge, check just after the rising edge
  task automatic apply(input vec_t v);
    @(negedge clk);
    cs = v.cs; we = v.we; addr = v.addr; wdata = v.wdata;
    rx_valid = v.rxv; rx_break = v.rxb; rx_data = v.rxd;
    @(posedge clk);
    #1;
    if (v.chk[0]) check8({v.name, ".rdata"}, rdata, v.exp_rd);
    if (v.chk[1]) check1({v.name, ".irq"},   irq,   v.exp_irq);
    if (v.chk[2]) check1({v.name, ".rx_en"}, rx_en, v.exp_en);
  endtask

  task automatic go_idle();
    @(negedge clk);
    cs = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00;
    rx_valid = 1'b0; rx_break = 1'b0; rx_data = 8'h00;
  endtask

  initial begin
    resetn = 1'b0;
    cs = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00;
    rx_valid = 1'b0; rx_break = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check8("reset.rdata", rdata, 8'h00);
    check1("reset.irq",   irq,   1'b0);
    check1("reset.rx_en", rx_en, 1'b1);

    // ---------------- vector table ----------------
    rd(2'd1, 8'h00, "rst_status");
    rd(2'd2, 8'h01, "rst_ctrl");
    rd(2'd3, 8'h00, "rst_count");
    // basic push / pop
    rx(8'h41); rx(8'h42); rx(8'h43);
    rd(2'd3, 8'h03, "count3");
    rd(2'd0, 8'h41, "pop41");
    rd(2'd0, 8'h42, "pop42");
    rd(2'd0, 8'h43, "pop43");
    rd(2'd0, 8'h00, "pop_empty");
    rd(2'd3, 8'h00, "count0");
    // fill to overrun; the 17th byte is dropped
    for (int i = 0; i < 17; i++) rx(8'(i));
    rd(2'd1, 8'h07, "status_full_ovr");
    rd(2'd3, 8'h10, "count_full");
    wr(2'd1, 8'h04);
    rd(2'd1, 8'h03, "status_ovr_clr");
    // push while full with a simultaneous pop: accepted, no overrun
    add(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h55, 3'b001, 8'h00, 1'b0, 1'b0, "pop_push_full");
    rd(2'd1, 8'h03, "status_no_ovr");
    for (int i = 1; i < 16; i++) rd(2'd0, 8'(i), "drain");
    rd(2'd0, 8'h55, "drain_55");
    rd(2'd3, 8'h00, "count_drained");
    // break and error interrupt
    add(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, "brk");
    rd(2'd3, 8'h00, "count_brk");
    rd(2'd1, 8'h08, "status_brk");
    wr(2'd2, 8'h05);
    idle_irq(1'b1, "irq_brk");
    rd(2'd1, 8'h88, "status_brk_irq");
    add(1'b1, 1'b1, 2'd1, 8'h08, 1'b0, 1'b0, 8'h00, 3'b010, 8'h00, 1'b1, 1'b0, "w1c_brk");
    idle_irq(1'b0, "irq_brk_clr");
    // set and clear of break in the same cycle: set wins
    add(1'b1, 1'b1, 2'd1, 8'h08, 1'b1, 1'b1, 8'h00, 3'b010, 8'h00, 1'b0, 1'b0, "set_wins");
    add(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 8'h00, 3'b011, 8'h08, 1'b1, 1'b0, "status_set_wins");
    add(1'b1, 1'b1, 2'd1, 8'h08, 1'b0, 1'b0, 8'h00, 3'b010, 8'h00, 1'b1, 1'b0, "w1c_brk2");
    idle_irq(1'b0, "irq_brk_clr2");
    // data interrupt
    wr(2'd2, 8'h03);
    add(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h7E, 3'b010, 8'h00, 1'b0, 1'b0, "push7e");
    idle_irq(1'b1, "irq_data");
    add(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 3'b011, 8'h7E, 1'b1, 1'b0, "pop7e");
    idle_irq(1'b0, "irq_data_fall");
    // flush with simultaneous push, enable bits kept
    for (int i = 1; i <= 5; i++) rx(8'(i));
    rd(2'd3, 8'h05, "count5");
    add(1'b1, 1'b1, 2'd2, 8'h09, 1'b1, 1'b0, 8'hAA, 3'b100, 8'h00, 1'b0, 1'b1, "flush");
    rd(2'd3, 8'h00, "count_flushed");
    rd(2'd2, 8'h01, "ctrl_after_flush");
    // receiver disabled: rx_valid ignored
    add(1'b1, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 8'h00, 3'b100, 8'h00, 1'b0, 1'b0, "rx_dis");
    rx(8'h99);
    add(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, "brk_dis");
    rd(2'd3, 8'h00, "count_dis");
    rd(2'd1, 8'h00, "status_dis");
    wr(2'd2, 8'h01);
    // writes leave rdata alone; DATA/COUNT writes ignored
    rd(2'd2, 8'h01, "ctrl_rd");
    add(1'b1, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0, 8'h00, 3'b001, 8'h01, 1'b0, 1'b0, "wr_keeps_rdata");
    wr(2'd0, 8'h12);
    rd(2'd3, 8'h00, "count_wr_ign");
    // push and pop on an empty FIFO
    add(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h33, 3'b001, 8'h00, 1'b0, 1'b0, "pop_push_empty");
    rd(2'd3, 8'h01, "count_pp_empty");
    rd(2'd0, 8'h33, "pop33");
    // set up state for the reset check
    rx(8'hA1); rx(8'hA2);
    wr(2'd2, 8'h07);
    rd(2'd2, 8'h07, "ctrl7");
    idle_irq(1'b1, "irq_pre_reset");

    foreach (tbl[i]) apply(tbl[i]);
    go_idle();

    // ---------------- reset during FIFO fill ----------------
    rx_valid = 1'b1; rx_data = 8'hC3;
    resetn = 1'b0;
    @(posedge clk); #1;
    check8("midrst.rdata", rdata, 8'h00);
    check1("midrst.irq",   irq,   1'b0);
    check1("midrst.rx_en", rx_en, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    resetn = 1'b1;

    tbl.delete();
    rd(2'd1, 8'h00, "post_rst_status");
    rd(2'd2, 8'h01, "post_rst_ctrl");
    rd(2'd3, 8'h00, "post_rst_count");
    rd(2'd0, 8'h00, "post_rst_data");
    idle_irq(1'b0, "post_rst_irq");
    foreach (tbl[i]) apply(tbl[i]);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
